// File: rtl/snake_pkg.sv
// Shared colour constants and display-state encoding for the snake renderer.
package snake_pkg;

    localparam logic [15:0] COL_BLACK  = 16'h0000;
    localparam logic [15:0] COL_BLUE   = 16'h001F;
    localparam logic [15:0] COL_GREEN  = 16'h07E0;
    localparam logic [15:0] COL_YELLOW = 16'hFFE0;
    localparam logic [15:0] COL_RED    = 16'hF800;
    localparam logic [15:0] COL_WHITE  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_OVER_ON  = 2'd1,
        ST_OVER_OFF = 2'd2
    } disp_state_t;

endpackage

// File: rtl/snake_hit_cmp.sv
// Square-hit comparator: flags a pixel inside a BLOCK_W x BLOCK_W square.
module snake_hit_cmp
    import snake_pkg::*;
#(
    parameter int BLOCK_W = 10
) (
    input  logic [9:0]  sq_x,
    input  logic [9:0]  sq_y,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic        hit
);

    logic [10:0] x_lo, x_hi, y_lo, y_hi;

    // Widened to 11 bits so a square near x=1023 extends past 1023 instead of wrapping to 0.
    assign x_lo = {1'b0, sq_x};
    assign y_lo = {1'b0, sq_y};
    assign x_hi = x_lo + 11'(BLOCK_W);
    assign y_hi = y_lo + 11'(BLOCK_W);

    assign hit = (xpos >= x_lo) && (xpos < x_hi) && (ypos >= y_lo) && (ypos < y_hi);

endmodule

// File: rtl/snake_render.sv
// Snake game pixel renderer: shadowed segment table, blink FSM, 2-stage colour pipeline.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_PLAY     | normal play, no game-over box
// ST_OVER_ON  | game over, box drawn this blink phase
// ST_OVER_OFF | game over, box hidden, snake/food/OSD still drawn
module snake_render
    import snake_pkg::*;
#(
    parameter int H_DISP       = 800,
    parameter int V_DISP       = 600,
    parameter int BLOCK_W      = 10,
    parameter int MAX_SEG      = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int OVR_X0       = 292,
    parameter int OVR_X1       = 508,
    parameter int OVR_Y0       = 168,
    parameter int OVR_Y1       = 232
) (
    input  logic                           vga_clk,
    input  logic                           sys_rst,
    input  logic [10:0]                    pixel_xpos,
    input  logic [10:0]                    pixel_ypos,
    input  logic                           pix_en,
    input  logic                           frame_start,
    input  logic                           seg_wr_en,
    input  logic [$clog2(MAX_SEG)-1:0]     seg_wr_idx,
    input  logic [9:0]                     seg_wr_x,
    input  logic [9:0]                     seg_wr_y,
    input  logic [$clog2(MAX_SEG+1)-1:0]   seg_len,
    input  logic [9:0]                     food_x,
    input  logic [9:0]                     food_y,
    input  logic                           game_over,
    input  logic                           osd_pix,
    output logic [15:0]                    pixel_data,
    output logic                           pixel_vld
);

    localparam int LEN_W = $clog2(MAX_SEG + 1);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]         live_x [MAX_SEG];
    logic [9:0]         live_y [MAX_SEG];
    logic [9:0]         shd_x  [MAX_SEG];
    logic [9:0]         shd_y  [MAX_SEG];
    logic [LEN_W-1:0]   shd_len;
    logic [9:0]         shd_food_x, shd_food_y;
    logic               shd_go;
    logic [MAX_SEG-1:0] wr_sel;
    logic [LEN_W-1:0]   len_clamped;

    disp_state_t        state, state_nxt;
    logic [CNT_W-1:0]   frm_cnt, frm_cnt_nxt;

    logic [10:0]        s1_x, s1_y;
    logic               s1_vld, s1_osd;
    logic [MAX_SEG:0]   hit;
    logic               body_hit, off_screen, in_box;
    logic [15:0]        colour;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < MAX_SEG; i++) begin
            wr_sel[i] = seg_wr_en && (int'(seg_wr_idx) == i);
        end
    end

    assign len_clamped = (int'(seg_len) > MAX_SEG) ? LEN_W'(MAX_SEG) : seg_len;

    // Shadow copy forwards a same-edge write so the frame sees the newest position.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < MAX_SEG; i++) begin
                live_x[i] <= '0;
                live_y[i] <= '0;
                shd_x[i]  <= '0;
                shd_y[i]  <= '0;
            end
            shd_len    <= '0;
            shd_food_x <= '0;
            shd_food_y <= '0;
            shd_go     <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_SEG; i++) begin
                if (wr_sel[i]) begin
                    live_x[i] <= seg_wr_x;
                    live_y[i] <= seg_wr_y;
                end
                if (frame_start) begin
                    shd_x[i] <= wr_sel[i] ? seg_wr_x : live_x[i];
                    shd_y[i] <= wr_sel[i] ? seg_wr_y : live_y[i];
                end
            end
            if (frame_start) begin
                shd_len    <= len_clamped;
                shd_food_x <= food_x;
                shd_food_y <= food_y;
                shd_go     <= game_over;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state   <= ST_PLAY;
            frm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            frm_cnt <= frm_cnt_nxt;
        end
    end

    // game_over here is the value being shadowed on this same frame_start edge.
    always_comb begin
        state_nxt   = state;
        frm_cnt_nxt = frm_cnt;
        if (frame_start) begin
            if (!game_over) begin
                state_nxt   = ST_PLAY;
                frm_cnt_nxt = '0;
            end else begin
                case (state)
                    ST_PLAY: begin
                        state_nxt   = ST_OVER_ON;
                        frm_cnt_nxt = '0;
                    end
                    ST_OVER_ON, ST_OVER_OFF: begin
                        if (frm_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                            state_nxt   = (state == ST_OVER_ON) ? ST_OVER_OFF : ST_OVER_ON;
                            frm_cnt_nxt = '0;
                        end else begin
                            frm_cnt_nxt = frm_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt   = ST_PLAY;
                        frm_cnt_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s1_x   <= '0;
            s1_y   <= '0;
            s1_vld <= 1'b0;
            s1_osd <= 1'b0;
        end else begin
            s1_x   <= pixel_xpos;
            s1_y   <= pixel_ypos;
            s1_vld <= pix_en;
            s1_osd <= osd_pix;
        end
    end

    for (genvar g = 0; g < MAX_SEG; g++) begin : g_seg_hit
        snake_hit_cmp #(.BLOCK_W(BLOCK_W)) u_seg_hit (
            .sq_x (shd_x[g]),
            .sq_y (shd_y[g]),
            .xpos (s1_x),
            .ypos (s1_y),
            .hit  (hit[g])
        );
    end

    snake_hit_cmp #(.BLOCK_W(BLOCK_W)) u_food_hit (
        .sq_x (shd_food_x),
        .sq_y (shd_food_y),
        .xpos (s1_x),
        .ypos (s1_y),
        .hit  (hit[MAX_SEG])
    );

    assign off_screen = (int'(s1_x) >= H_DISP) || (int'(s1_y) >= V_DISP);
    assign in_box     = (int'(s1_x) >= OVR_X0) && (int'(s1_x) < OVR_X1) &&
                        (int'(s1_y) >= OVR_Y0) && (int'(s1_y) < OVR_Y1);

    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_SEG; i++) begin
            if (hit[i] && (int'(shd_len) > i)) body_hit = 1'b1;
        end
        colour = COL_WHITE;
        if (off_screen)                          colour = COL_BLACK;
        else if (state == ST_OVER_ON && in_box)  colour = COL_BLACK;
        else if (hit[0] && shd_len != '0)        colour = COL_BLUE;
        else if (body_hit)                       colour = COL_GREEN;
        else if (hit[MAX_SEG])                   colour = COL_YELLOW;
        else if (s1_osd)                         colour = COL_RED;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pixel_data <= COL_BLACK;
            pixel_vld  <= 1'b0;
        end else begin
            pixel_data <= colour;
            pixel_vld  <= s1_vld;
        end
    end

endmodule
